// File: rtl/router_pkt_tx_pkg.sv
// Shared types, constants and helpers for the router packet transmitter.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_e;

  localparam logic [1:0] ADDR_INVALID = 2'd3;
  localparam int         MAX_LEN      = 63;

  function automatic logic [7:0] mk_header(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Upstream stream, command and router-side signals of the packet transmitter.
interface router_pkt_tx_if #(
  parameter int CNT_W = 7
);
  logic             s_data_dummy_unused_guard;
  logic [7:0]       s_data;
  logic             s_valid;
  logic             s_ready;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_addr;
  logic [5:0]       cmd_len;
  logic             cmd_corrupt;
  logic             busy;
  logic             err;
  logic [7:0]       d_out;
  logic             pkt_valid;
  logic             pkt_done;
  logic             pkt_err;
  logic             cmd_rej;
  logic [CNT_W-1:0] fifo_count;

  // Transmitter side.
  modport master (
    input  s_data, s_valid, cmd_valid, cmd_addr, cmd_len, cmd_corrupt, busy, err,
    output s_ready, cmd_ready, d_out, pkt_valid, pkt_done, pkt_err, cmd_rej, fifo_count
  );

  // Host / router side.
  modport slave (
    output s_data, s_valid, cmd_valid, cmd_addr, cmd_len, cmd_corrupt, busy, err,
    input  s_ready, cmd_ready, d_out, pkt_valid, pkt_done, pkt_err, cmd_rej, fifo_count
  );
endinterface

// File: rtl/router_pkt_tx_fifo.sv
// First-word-fall-through byte FIFO buffering the packet payload.
module router_tx_fifo #(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/router_pkt_tx.sv
// Router input-side packet transmitter: buffers payload, then sends header,
// payload and parity as one busy-respecting burst and reports the err verdict.
//
// state     | meaning
// IDLE      | accepting commands; illegal ones pulse cmd_rej
// WAIT_DATA | command latched, waiting for len bytes in the buffer
// HEADER    | header byte on d_out, pkt_valid high
// PAYLOAD   | FIFO head on d_out, pkt_valid high
// PARITY    | parity byte on d_out, pkt_valid low
// GAP       | idle window, router err sampled; pkt_done on last cycle
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int GAP_CYCLES = 3,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input logic            clk,
  input logic            rst,
  router_pkt_tx_if.master bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  tx_state_e        r_state;
  tx_state_e        w_next;
  logic [1:0]       r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_remaining;
  logic             r_corrupt;
  logic [7:0]       r_parity;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_err_seen;
  logic             r_cmd_rej;

  logic             w_accept;
  logic             w_pop;
  logic             w_cmd_take;
  logic             w_cmd_bad;
  logic             w_data_ready;
  logic             w_gap_last;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [7:0]       w_head;
  logic [7:0]       w_header;
  logic [CNT_W-1:0] w_count;

  router_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.s_valid),
    .i_data  (bus.s_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count)
  );

  assign w_header       = mk_header(r_len, r_addr);
  assign w_accept       = !bus.busy;
  assign w_cmd_bad      = (bus.cmd_addr == ADDR_INVALID) || (bus.cmd_len == '0);
  assign w_data_ready   = (w_count >= CNT_W'(r_len));
  assign w_gap_last     = (r_gap_cnt == '0);
  assign bus.s_ready    = !w_fifo_full;
  assign bus.cmd_rej    = r_cmd_rej;
  assign bus.fifo_count = w_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_pop         = 1'b0;
    w_cmd_take    = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.pkt_valid = 1'b0;
    bus.d_out     = 8'h00;
    bus.pkt_done  = 1'b0;
    bus.pkt_err   = 1'b0;
    case (r_state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_cmd_take = 1'b1;
          if (!w_cmd_bad) w_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (w_data_ready) w_next = HEADER;
      end
      HEADER: begin
        bus.pkt_valid = 1'b1;
        bus.d_out     = w_header;
        if (w_accept) w_next = PAYLOAD;
      end
      PAYLOAD: begin
        bus.pkt_valid = 1'b1;
        bus.d_out     = w_head;
        if (w_accept) begin
          w_pop = !w_fifo_empty;
          if (r_remaining == LEN_W'(1)) w_next = PARITY;
        end
      end
      PARITY: begin
        bus.d_out = r_corrupt ? ~r_parity : r_parity;
        if (w_accept) w_next = GAP;
      end
      GAP: begin
        // err on the final gap cycle still counts toward this packet.
        if (w_gap_last) begin
          bus.pkt_done = 1'b1;
          bus.pkt_err  = r_err_seen | bus.err;
          w_next       = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_corrupt   <= 1'b0;
      r_parity    <= '0;
      r_remaining <= '0;
      r_gap_cnt   <= '0;
      r_err_seen  <= 1'b0;
      r_cmd_rej   <= 1'b0;
    end else begin
      r_cmd_rej <= w_cmd_take && w_cmd_bad;
      if (w_cmd_take) begin
        r_addr    <= bus.cmd_addr;
        r_len     <= bus.cmd_len;
        r_corrupt <= bus.cmd_corrupt;
      end
      case (r_state)
        HEADER: if (w_accept) begin
          r_parity    <= w_header;
          r_remaining <= r_len;
        end
        PAYLOAD: if (w_accept) begin
          r_parity    <= r_parity ^ w_head;
          r_remaining <= r_remaining - 1'b1;
        end
        PARITY: if (w_accept) begin
          r_gap_cnt  <= GAP_W'(GAP_CYCLES - 1);
          r_err_seen <= 1'b0;
        end
        GAP: begin
          r_err_seen <= w_gap_last ? 1'b0 : (r_err_seen | bus.err);
          if (!w_gap_last) r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx.
module tb_router_pkt_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_pkt_tx_if #(.CNT_W(7)) bus();

  router_pkt_tx #(.FIFO_DEPTH(64), .GAP_CYCLES(3), .CNT_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_bytes [0:127];
  logic [7:0] exp_b [0:127];
  int         cap_n;
  logic [7:0] cap_par;
  bit         cap_got_par, cap_done, cap_err;
  int         cap_unstable;

  task automatic push(input logic [7:0] b);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic c);
    int k = 0;
    while (!bus.cmd_ready && k < 100) begin @(negedge clk); k++; end
    if (k == 100) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=0 want 1 within 100 cycles");
    end
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_corrupt = c;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Records accepted bytes, the parity byte and the pkt_done verdict.
  task automatic capture(input int budget);
    bit         seen_v = 1'b0;
    bit         pb = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       pv = 1'b0;
    cap_n = 0; cap_got_par = 0; cap_done = 0; cap_err = 0; cap_unstable = 0; cap_par = 8'h00;
    for (int c = 0; c < budget && !cap_done; c++) begin
      @(negedge clk);
      if (bus.busy && pb && (bus.d_out !== pd || bus.pkt_valid !== pv)) cap_unstable++;
      pd = bus.d_out; pv = bus.pkt_valid; pb = bus.busy;
      if (bus.pkt_valid) begin
        seen_v = 1'b1;
        if (!bus.busy && cap_n < 128) begin cap_bytes[cap_n] = bus.d_out; cap_n++; end
      end else if (seen_v && !cap_got_par && !bus.busy) begin
        cap_par = bus.d_out; cap_got_par = 1'b1;
      end
      if (bus.pkt_done) begin cap_done = 1'b1; cap_err = bus.pkt_err; end
    end
  endtask

  task automatic test_reset();
    bus.s_valid = 0; bus.s_data = 0; bus.cmd_valid = 0; bus.cmd_addr = 0;
    bus.cmd_len = 0; bus.cmd_corrupt = 0; bus.busy = 0; bus.err = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out: got %h want 00", bus.d_out); end
    checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid: got %b want 0", bus.pkt_valid); end
    checks++; if (bus.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_pkt_done: got %b want 0", bus.pkt_done); end
    checks++; if (bus.pkt_err !== 1'b0) begin errors++; $display("FAIL reset_pkt_err: got %b want 0", bus.pkt_err); end
    checks++; if (bus.cmd_rej !== 1'b0) begin errors++; $display("FAIL reset_cmd_rej: got %b want 0", bus.cmd_rej); end
    checks++; if (bus.fifo_count !== 7'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    push(8'hA5);
    checks++; if (bus.fifo_count !== 7'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", bus.fifo_count); end
    send_cmd(2'd0, 6'd1, 1'b0);
    capture(20);
    checks++; if (cap_n !== 2) begin errors++; $display("FAIL basic_len: got %0d want 2", cap_n); end
    checks++; if (cap_bytes[0] !== 8'h04) begin errors++; $display("FAIL basic_header: got %h want 04", cap_bytes[0]); end
    checks++; if (cap_bytes[1] !== 8'hA5) begin errors++; $display("FAIL basic_payload: got %h want A5", cap_bytes[1]); end
    checks++; if (cap_par !== 8'hA1) begin errors++; $display("FAIL basic_parity: got %h want A1", cap_par); end
    checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", cap_done); end
    checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", cap_err); end
    checks++; if (bus.fifo_count !== 7'd0) begin errors++; $display("FAIL basic_drain: got %0d want 0", bus.fifo_count); end
  endtask

  task automatic test_busy_stall();
    exp_b[0] = 8'h22;
    for (int i = 0; i < 8; i++) begin
      exp_b[i+1] = 8'(8'h11 * (i + 1));
      push(exp_b[i+1]);
    end
    send_cmd(2'd2, 6'd8, 1'b0);
    fork
      capture(60);
      begin
        int k = 0;
        while (!bus.pkt_valid && k < 40) begin @(posedge clk); #1; k++; end
        bus.busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.busy = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.busy = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.busy = 1'b0;
      end
    join
    checks++; if (cap_n !== 9) begin errors++; $display("FAIL stall_len: got %0d want 9", cap_n); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (cap_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, cap_bytes[i], exp_b[i]); end
    end
    checks++; if (cap_par !== 8'hAA) begin errors++; $display("FAIL stall_parity: got %h want AA", cap_par); end
    checks++; if (cap_unstable !== 0) begin errors++; $display("FAIL stall_hold: got %0d changes while busy want 0", cap_unstable); end
    checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", cap_done); end
  endtask

  task automatic test_reject();
    logic [1:0] a;
    logic [5:0] l;
    bit         act;
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 2'd3 : 2'd1;
      l = (t == 0) ? 6'd5 : 6'd0;
      send_cmd(a, l, 1'b0);
      checks++; if (bus.cmd_rej !== 1'b1) begin errors++; $display("FAIL rej%0d_pulse: got %b want 1", t, bus.cmd_rej); end
      @(negedge clk);
      checks++; if (bus.cmd_rej !== 1'b0) begin errors++; $display("FAIL rej%0d_clear: got %b want 0", t, bus.cmd_rej); end
      act = 1'b0;
      repeat (6) begin @(negedge clk); if (bus.pkt_valid !== 1'b0) act = 1'b1; end
      checks++; if (act !== 1'b0) begin errors++; $display("FAIL rej%0d_quiet: got pkt_valid activity want none", t); end
      checks++; if (bus.fifo_count !== 7'd0) begin errors++; $display("FAIL rej%0d_count: got %0d want 0", t, bus.fifo_count); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rej%0d_idle: got cmd_ready=%b want 1", t, bus.cmd_ready); end
    end
  endtask

  task automatic test_wait_data();
    bit act = 1'b0;
    exp_b[0] = 8'h19;
    for (int i = 1; i <= 6; i++) exp_b[i] = 8'(i);
    for (int i = 1; i <= 3; i++) push(exp_b[i]);
    send_cmd(2'd1, 6'd6, 1'b0);
    repeat (5) begin @(negedge clk); if (bus.pkt_valid !== 1'b0) act = 1'b1; end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL wait_quiet: got pkt_valid activity want none"); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL wait_blocked: got cmd_ready=%b want 0", bus.cmd_ready); end
    checks++; if (bus.fifo_count !== 7'd3) begin errors++; $display("FAIL wait_count: got %0d want 3", bus.fifo_count); end
    for (int i = 4; i <= 6; i++) push(exp_b[i]);
    fork
      capture(60);
      begin
        int k = 0;
        while (!bus.pkt_valid && k < 40) begin @(negedge clk); k++; end
        @(negedge clk);
        bus.s_valid = 1'b1; bus.s_data = 8'h77;
        @(negedge clk);
        bus.s_valid = 1'b0;
        checks++; if (bus.fifo_count !== 7'd6) begin errors++; $display("FAIL wait_pushpop: got %0d want 6", bus.fifo_count); end
      end
    join
    checks++; if (cap_n !== 7) begin errors++; $display("FAIL wait_len: got %0d want 7", cap_n); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cap_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL wait_byte%0d: got %h want %h", i, cap_bytes[i], exp_b[i]); end
    end
    checks++; if (cap_par !== 8'h1E) begin errors++; $display("FAIL wait_parity: got %h want 1E", cap_par); end
    checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL wait_done: got %b want 1", cap_done); end
    @(negedge clk);
    checks++; if (bus.fifo_count !== 7'd1) begin errors++; $display("FAIL wait_leftover: got %0d want 1", bus.fifo_count); end
  endtask

  task automatic test_corrupt();
    logic [7:0] x = 8'h00;
    exp_b[0] = 8'h39;
    exp_b[1] = 8'h77;
    for (int i = 0; i < 13; i++) begin
      exp_b[i+2] = 8'(8'hC0 + i);
      push(exp_b[i+2]);
    end
    for (int i = 0; i < 15; i++) x = x ^ exp_b[i];
    send_cmd(2'd1, 6'd14, 1'b1);
    fork
      capture(80);
      begin
        int k = 0;
        while (!bus.pkt_valid && k < 60) begin @(negedge clk); k++; end
        while (bus.pkt_valid && k < 60) begin @(negedge clk); k++; end
        bus.err = 1'b1;
        repeat (2) @(negedge clk);
        bus.err = 1'b0;
      end
    join
    checks++; if (cap_n !== 15) begin errors++; $display("FAIL corrupt_len: got %0d want 15", cap_n); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (cap_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL corrupt_byte%0d: got %h want %h", i, cap_bytes[i], exp_b[i]); end
    end
    checks++; if (cap_par !== ~x) begin errors++; $display("FAIL corrupt_parity: got %h want %h", cap_par, ~x); end
    checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL corrupt_done: got %b want 1", cap_done); end
    checks++; if (cap_err !== 1'b1) begin errors++; $display("FAIL corrupt_pkt_err: got %b want 1", cap_err); end
  endtask

  task automatic test_reset_mid();
    bit act = 1'b0;
    int k = 0;
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    send_cmd(2'd0, 6'd20, 1'b0);
    while (!bus.pkt_valid && k < 60) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.pkt_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pkt_valid: got %b want 0", bus.pkt_valid); end
    checks++; if (bus.d_out !== 8'h00) begin errors++; $display("FAIL rstmid_d_out: got %h want 00", bus.d_out); end
    checks++; if (bus.fifo_count !== 7'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.fifo_count); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready: got %b want 1", bus.cmd_ready); end
    @(negedge clk);
    rst = 1'b1;
    repeat (30) begin @(negedge clk); if (bus.pkt_done !== 1'b0 || bus.pkt_valid !== 1'b0) act = 1'b1; end
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got packet activity after abort want none"); end
    push(8'hE1);
    push(8'hE2);
    send_cmd(2'd2, 6'd2, 1'b0);
    capture(30);
    checks++; if (cap_n !== 3) begin errors++; $display("FAIL after_len: got %0d want 3", cap_n); end
    checks++; if (cap_bytes[0] !== 8'h0A) begin errors++; $display("FAIL after_header: got %h want 0A", cap_bytes[0]); end
    checks++; if (cap_bytes[1] !== 8'hE1) begin errors++; $display("FAIL after_byte1: got %h want E1", cap_bytes[1]); end
    checks++; if (cap_bytes[2] !== 8'hE2) begin errors++; $display("FAIL after_byte2: got %h want E2", cap_bytes[2]); end
    checks++; if (cap_par !== 8'h09) begin errors++; $display("FAIL after_parity: got %h want 09", cap_par); end
    checks++; if (cap_done !== 1'b1) begin errors++; $display("FAIL after_done: got %b want 1", cap_done); end
    checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL after_pkt_err: got %b want 0", cap_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_stall();
    test_reject();
    test_wait_data();
    test_corrupt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
